if_program_loader: RTL and testbench
====================================

// Module: if_program_loader
// PURPOSE
//  Debug-unit loader that sits directly upstream of the IF stage's instruction memory.
//  Accepts a byte stream (UART RX side) over a valid/ready handshake.
//  Drives the IF memory write port (im_enable, write_enable, 8-bit data, byte address) and holds PC in reset while loading.
//  Stops on a HALT instruction word and reports done, or reports error on overflow.
// PARAMETERS
//  NB_PC          32            width of write address / byte counter
//  NB_INSTRUCTION 32            instruction word width (multiple of NB_MEM_WIDTH)
//  NB_MEM_WIDTH   8             byte width of stream and memory write data
//  IMEM_BYTES     1024          instruction memory capacity in bytes (multiple of 4)
//  HALT_WORD      32'hFFFFFFFF  instruction that terminates loading
// PORTS
//  i_clock        in   1       clock, all state updates on rising edge
//  i_reset        in   1       asynchronous, active-high reset
//  i_start        in   1       1-cycle pulse: begin a new load
//  i_rx_valid     in   1       stream byte valid
//  i_rx_data      in   8       stream byte
//  o_rx_ready     out  1       loader accepts a byte this cycle
//  o_im_enable    out  1       to IF i_IF_im_enable
//  o_write_enable out  1       to IF i_IF_write_enable (1-cycle pulse per byte)
//  o_write_data   out  8       to IF i_IF_write_data
//  o_write_addr   out  NB_PC   to IF i_IF_write_addr (byte address)
//  o_pc_reset     out  1       to IF i_IF_pc_reset; high while LOAD
//  o_done         out  1       level; load ended on HALT_WORD
//  o_error        out  1       level; memory filled without HALT_WORD
//  o_byte_count   out  NB_PC   bytes written in current/last load
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, o_write_addr=0, o_byte_count=0; byte assembler cleared.
//  FSM states: IDLE, LOAD, DONE, ERROR.
//   IDLE  -> LOAD on i_start; at the entry edge addr=0, byte_count=0, assembler cleared, done/error cleared.
//   LOAD  -> DONE when the 4th byte of a word completes a word equal to HALT_WORD.
//   LOAD  -> ERROR when byte IMEM_BYTES-1 is accepted and the word is not HALT.
//   DONE/ERROR -> LOAD on i_start (same init as IDLE->LOAD).
//   i_start during LOAD is ignored.
//  Handshake:
//   - o_rx_ready = (state==LOAD), combinational from state.
//   - A byte is accepted when i_rx_valid & o_rx_ready; no back-pressure within LOAD.
//  Write timing: 1-cycle latency, registered.
//   - Accept in cycle N -> cycle N+1: o_write_enable=1, o_write_data=byte, o_write_addr=address of that byte.
//   - Address increments by 1 per accepted byte; byte_count updates in the same cycle N+1.
//   - o_write_enable is 0 in any cycle without a preceding accept.
//  o_im_enable = 1 in LOAD and in the cycle of any pending write (covers the final HALT byte written after LOAD->DONE).
//  Word assembly: big-endian. Bytes b0..b3 at addr 4k..4k+3 form {b0,b1,b2,b3}.
//   - HALT compare happens only when addr[1:0]==3 on accept.
//   - HALT bytes are written to memory like any others.
//  o_pc_reset: 1 in LOAD, 0 otherwise; PC is released the cycle after entering DONE.
//  Boundary conditions:
//   - HALT completing at byte IMEM_BYTES-1 -> DONE (HALT has priority over ERROR).
//   - No address wrap: ERROR is entered before addr can reach IMEM_BYTES.
//   - i_rx_valid in IDLE/DONE/ERROR: not accepted, no write.
//   - i_reset mid-LOAD: immediate return to reset values; any pending write is dropped.
//     Memory contents are then undefined and must be reloaded.
// TESTING
//  1. Reset -> all outputs 0; i_rx_valid=1 in IDLE -> o_rx_ready=0, no write.
//  2. start; stream 00 11 22 33 FF FF FF FF:
//     -> 8 writes, addr 0..7, data in order, each 1 cycle after accept; o_done=1; o_byte_count=8; o_pc_reset falls.
//  3. Bytes FF FF FF at addr 0..2 then 00: no halt; then FF FF FF FF at addr 4..7 -> done, byte_count=8.
//  4. IMEM_BYTES=16, 16 bytes of 0x00 -> o_error=1, byte_count=16, no 17th write.
//     Same depth with HALT as word 3 -> o_done=1, not error.
//  5. Gapped i_rx_valid (1 of every 3 cycles): writes occur only after accepts; addresses contiguous.
//  6. Assert i_reset after 5 accepted bytes -> outputs 0 at once, no pending write.
//     Then start + HALT-only stream -> writes at addr 0..3, done.

Source files
------------

// File: rtl/if_program_loader.sv
// Debug loader feeding the IF instruction memory write port from a byte stream.
// Holds the PC in reset while loading; ends on HALT_WORD (done) or a full memory (error).
module if_program_loader #(
  parameter int                          NB_PC          = 32,
  parameter int                          NB_INSTRUCTION = 32,
  parameter int                          NB_MEM_WIDTH   = 8,
  parameter int                          IMEM_BYTES     = 1024,
  parameter logic [NB_INSTRUCTION-1:0]   HALT_WORD      = 32'hFFFFFFFF
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_rx_valid,
  input  logic [NB_MEM_WIDTH-1:0] i_rx_data,
  output logic                    o_rx_ready,
  output logic                    o_im_enable,
  output logic                    o_write_enable,
  output logic [NB_MEM_WIDTH-1:0] o_write_data,
  output logic [NB_PC-1:0]        o_write_addr,
  output logic                    o_pc_reset,
  output logic                    o_done,
  output logic                    o_error,
  output logic [NB_PC-1:0]        o_byte_count
);
  localparam int BPW    = NB_INSTRUCTION / NB_MEM_WIDTH;
  localparam int NB_SEL = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int NB_ASM = NB_INSTRUCTION - NB_MEM_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERROR} state_t;

  state_t                  r_state;
  logic [NB_PC-1:0]        r_addr;
  logic [NB_PC-1:0]        r_byte_count;
  logic [NB_ASM-1:0]       r_asm;
  logic                    r_wr_en;
  logic [NB_MEM_WIDTH-1:0] r_wr_data;
  logic [NB_PC-1:0]        r_wr_addr;
  logic                    r_done;
  logic                    r_error;

  logic                      w_accept;
  logic                      w_last;
  logic                      w_halt;
  logic                      w_full;
  logic [NB_INSTRUCTION-1:0] w_word;

  assign w_accept = i_rx_valid && (r_state == LOAD);
  assign w_word   = {r_asm, i_rx_data};
  assign w_last   = (r_addr[NB_SEL-1:0] == NB_SEL'(BPW - 1));
  assign w_halt   = w_last && (w_word == HALT_WORD);
  assign w_full   = (r_addr == NB_PC'(IMEM_BYTES - 1));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_byte_count <= '0;
      r_asm        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_data    <= '0;
      r_wr_addr    <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_data    <= i_rx_data;
        r_wr_addr    <= r_addr;
        r_addr       <= r_addr + 1'b1;
        r_byte_count <= r_addr + 1'b1;
        // Assembler only ever needs the leading bytes of the current word.
        r_asm        <= w_last ? '0 : NB_ASM'({r_asm, i_rx_data});
      end
      case (r_state)
        LOAD: begin
          if (w_accept && w_halt) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else if (w_accept && w_full) begin
            r_state <= ERROR;
            r_error <= 1'b1;
          end
        end
        default: begin
          if (i_start) begin
            r_state      <= LOAD;
            r_addr       <= '0;
            r_byte_count <= '0;
            r_asm        <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
          end
        end
      endcase
    end
  end

  // im_enable stays up one extra cycle so the final HALT byte still lands.
  assign o_rx_ready     = (r_state == LOAD);
  assign o_pc_reset     = (r_state == LOAD);
  assign o_im_enable    = (r_state == LOAD) || r_wr_en;
  assign o_write_enable = r_wr_en;
  assign o_write_data   = r_wr_data;
  assign o_write_addr   = r_wr_addr;
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_byte_count   = r_byte_count;
endmodule

// File: tb/tb_if_program_loader.sv
// Directed bench for if_program_loader: scoreboard of expected memory writes
// popped by a write monitor, plus status checks after each phase.
module tb_if_program_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready, im_en, wr_en, pc_rst, done, err;
  logic [7:0]  wr_data;
  logic [31:0] wr_addr, byte_cnt;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] exp_addr;
  int          checks   = 0;
  int          failures = 0;

  if_program_loader #(.IMEM_BYTES(16)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start),
    .i_rx_valid(rx_valid), .i_rx_data(rx_data), .o_rx_ready(rx_ready),
    .o_im_enable(im_en), .o_write_enable(wr_en), .o_write_data(wr_data),
    .o_write_addr(wr_addr), .o_pc_reset(pc_rst), .o_done(done),
    .o_error(err), .o_byte_count(byte_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every write the DUT makes must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) chk("spurious_write", {63'd0, wr_en}, 64'd0);
      else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", {32'd0, wr_addr}, {32'd0, e.addr});
        chk("wr_data", {56'd0, wr_data}, {56'd0, e.data});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    wr_t e;
    rx_valid = 1'b1;
    rx_data  = b;
    e.addr = exp_addr;
    e.data = b;
    sb.push_back(e);
    exp_addr++;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk); #1;
    chk("write_latency", {32'd0, sb.size()}, 64'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = '0;
    @(negedge clk);
    chk("start_ready", {63'd0, rx_ready}, 64'd1);
    chk("start_pcrst", {63'd0, pc_rst}, 64'd1);
    chk("start_flags", {62'd0, done, err}, 64'd0);
    chk("start_count", {32'd0, byte_cnt}, 64'd0);
  endtask

  task automatic send_halt();
    repeat (4) send_byte(8'hFF);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; exp_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {rx_ready, im_en, wr_en, pc_rst, done, err, wr_data, wr_addr},
        64'd0);
    chk("reset_count", {32'd0, byte_cnt}, 64'd0);
    #1 rst = 1'b0;

    // Valid data while idle must be ignored.
    rx_valid = 1'b1; rx_data = 8'hAA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_ready", {63'd0, rx_ready}, 64'd0);
    chk("idle_no_write", {63'd0, wr_en}, 64'd0);
    #1 rx_valid = 1'b0;

    // Basic program followed by HALT.
    @(posedge clk); #1;
    pulse_start();
    send_byte(8'h00); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    chk("prog_not_done", {63'd0, done}, 64'd0);
    send_halt();
    chk("prog_done", {63'd0, done}, 64'd1);
    chk("prog_count", {32'd0, byte_cnt}, 64'd8);
    chk("prog_pc_released", {63'd0, pc_rst}, 64'd0);
    chk("prog_im_final", {63'd0, im_en}, 64'd1);
    @(negedge clk);
    chk("prog_im_off", {63'd0, im_en}, 64'd0);
    chk("prog_error", {63'd0, err}, 64'd0);

    // FF FF FF 00 is not a HALT; only an aligned full word counts.
    #1 pulse_start();
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h00);
    chk("nohalt_done", {63'd0, done}, 64'd0);
    chk("nohalt_ready", {63'd0, rx_ready}, 64'd1);
    send_halt();
    chk("halt2_done", {63'd0, done}, 64'd1);
    chk("halt2_count", {32'd0, byte_cnt}, 64'd8);

    // Fill 16-byte memory without HALT -> error, further bytes rejected.
    #1 pulse_start();
    repeat (16) send_byte(8'h00);
    chk("ovf_error", {63'd0, err}, 64'd1);
    chk("ovf_done", {63'd0, done}, 64'd0);
    chk("ovf_count", {32'd0, byte_cnt}, 64'd16);
    chk("ovf_ready", {63'd0, rx_ready}, 64'd0);
    rx_valid = 1'b1; rx_data = 8'h5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ovf_no_17th", {63'd0, wr_en}, 64'd0);
    #1 rx_valid = 1'b0;

    // HALT in the last word has priority over the overflow.
    pulse_start();
    repeat (12) send_byte(8'h00);
    send_halt();
    chk("lastword_done", {63'd0, done}, 64'd1);
    chk("lastword_error", {63'd0, err}, 64'd0);
    chk("lastword_count", {32'd0, byte_cnt}, 64'd16);

    // Gapped stream; a start pulse mid-load must not restart addressing.
    #1 pulse_start();
    for (int i = 1; i <= 4; i++) begin
      send_byte(8'(i));
      if (i == 2) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
    end
    chk("gap_count", {32'd0, byte_cnt}, 64'd4);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hFF);
      repeat (2) begin @(posedge clk); #1; end
    end
    chk("gap_done", {63'd0, done}, 64'd1);
    chk("gap_total", {32'd0, byte_cnt}, 64'd8);

    // Reset right after the 5th accept drops its pending write.
    pulse_start();
    repeat (4) send_byte(8'h77);
    rx_valid = 1'b1; rx_data = 8'h88;
    @(posedge clk); #1;
    rst = 1'b1; rx_valid = 1'b0;
    #1;
    chk("midreset_outputs", {rx_ready, im_en, wr_en, pc_rst, done, err, wr_data, wr_addr},
        64'd0);
    chk("midreset_count", {32'd0, byte_cnt}, 64'd0);
    @(negedge clk);
    chk("midreset_no_write", {63'd0, wr_en}, 64'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    pulse_start();
    send_halt();
    chk("reload_done", {63'd0, done}, 64'd1);
    chk("reload_count", {32'd0, byte_cnt}, 64'd4);
    @(negedge clk);
    chk("sb_drained", {32'd0, sb.size()}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
